// File: rtl/mdu_pkg.sv
// Shared constants for the HI/LO multiply unit: op encodings, FSM state
// encoding and the default multiplier latency.
package mdu_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_MTHI  = 3'd3;
  localparam logic [2:0] OP_MTLO  = 3'd4;
  localparam logic [2:0] OP_MFHI  = 3'd5;
  localparam logic [2:0] OP_MFLO  = 3'd6;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam int MUL_LAT_DEFAULT = 3;

endpackage

// File: rtl/mdu_ufix.sv
// Turns the signed 64-bit product of two 32-bit operands into the unsigned
// product when the original op was MULTU.
module mdu_ufix (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] z,
  input  logic        is_unsigned,
  output logic [63:0] res
);

  logic [63:0] w_corr_a;
  logic [63:0] w_corr_b;

  // An operand with bit 31 set was read as value - 2^32 by the signed MUL;
  // adding the other operand shifted by 32 undoes that, modulo 2^64.
  always_comb begin
    w_corr_a = 64'd0;
    w_corr_b = 64'd0;
    res      = z;
    if (a[31]) begin
      w_corr_a = {b, 32'd0};
    end else begin
      w_corr_a = 64'd0;
    end
    if (b[31]) begin
      w_corr_b = {a, 32'd0};
    end else begin
      w_corr_b = 64'd0;
    end
    if (is_unsigned) begin
      res = z + w_corr_a + w_corr_b;
    end else begin
      res = z;
    end
  end

endmodule

// File: rtl/hilo_mdu.sv
// HI/LO register file with a two-state sequencer around an external,
// fixed-latency signed multiplier.
module hilo_mdu
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_z,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [0:0]  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_unsigned;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_is_mul;
  logic        w_is_mthi;
  logic        w_is_mtlo;
  logic        w_is_mfhi;
  logic        w_is_mflo;
  logic        w_is_valid;
  logic        w_busy;
  logic [63:0] w_prod;

  mdu_ufix u_ufix (
    .a           (r_a),
    .b           (r_b),
    .z           (mul_z),
    .is_unsigned (r_unsigned),
    .res         (w_prod)
  );

  // Decode; undefined encodings fall out as NOP.
  always_comb begin
    w_is_mul   = 1'b0;
    w_is_mthi  = 1'b0;
    w_is_mtlo  = 1'b0;
    w_is_mfhi  = 1'b0;
    w_is_mflo  = 1'b0;
    w_is_valid = 1'b1;
    case (op)
      OP_MULT, OP_MULTU: w_is_mul  = 1'b1;
      OP_MTHI:           w_is_mthi = 1'b1;
      OP_MTLO:           w_is_mtlo = 1'b1;
      OP_MFHI:           w_is_mfhi = 1'b1;
      OP_MFLO:           w_is_mflo = 1'b1;
      default:           w_is_valid = 1'b0;
    endcase
  end

  assign w_busy = (r_state == ST_WAIT);

  // Reads forward the product being written on the done cycle.
  always_comb begin
    rd_data = 32'd0;
    if (w_is_mfhi) begin
      rd_data = r_done ? w_prod[63:32] : r_hi;
    end else if (w_is_mflo) begin
      rd_data = r_done ? w_prod[31:0] : r_lo;
    end else begin
      rd_data = 32'd0;
    end
  end

  // Sequencer: the done cycle is spent in IDLE so the next op is not stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_unsigned <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_is_mul) begin
            r_a        <= rs_val;
            r_b        <= rt_val;
            r_unsigned <= (op == OP_MULTU);
            r_cnt      <= 4'(MUL_LAT);
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt <= 4'd1) begin
            r_cnt   <= 4'd0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // HI/LO write port; a move issued on the done cycle is younger and wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else begin
      if (r_done) begin
        r_hi <= w_prod[63:32];
        r_lo <= w_prod[31:0];
      end
      if (!w_busy && w_is_mthi) begin
        r_hi <= rs_val;
      end
      if (!w_busy && w_is_mtlo) begin
        r_lo <= rs_val;
      end
    end
  end

  assign mul_a = r_a;
  assign mul_b = r_b;
  assign busy  = w_busy;
  assign stall = w_busy & w_is_valid & (op != OP_NOP);
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed bench for hilo_mdu with a pipelined signed multiplier model.
module tb_hilo_mdu;
  import mdu_pkg::*;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_z;
  logic [31:0] rd_data;
  logic        busy, stall, done;
  logic [31:0] hi, lo;
  logic [63:0] r_pipe [LAT];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_done;

  hilo_mdu #(.MUL_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z), .rd_data(rd_data),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // External signed MUL: LAT register stages.
  always_ff @(posedge clk) begin
    r_pipe[0] <= $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
    for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
  end
  assign mul_z = r_pipe[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_mul(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input string tag);
    op = o; rs_val = a; rt_val = b;
    #1;
    chk({tag, "_stall0"}, {63'd0, stall}, 64'd0);
    tick;
    op = OP_NOP;
    #1;
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    chk({tag, "_mula"}, {32'd0, mul_a}, {32'd0, a});
    chk({tag, "_mulb"}, {32'd0, mul_b}, {32'd0, b});
    for (int k = 1; k < LAT; k++) tick;
    chk({tag, "_busy_late"}, {62'd0, busy, done}, 64'd2);
    tick;
    chk({tag, "_done"}, {62'd0, busy, done}, 64'd1);
    tick;
    chk({tag, "_hilo"}, {hi, lo}, {eh, el});
    chk({tag, "_done_off"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; op = OP_NOP; rs_val = 32'd0; rt_val = 32'd0;
    tick; tick;
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_mul", {mul_a, mul_b}, 64'd0);
    chk("rst_flags", {61'd0, busy, stall, done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_mul(OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, "mult_m1");
    run_mul(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
    run_mul(OP_MULT,  32'h80000000, 32'hAAAAAAAA, 32'h2AAAAAAB, 32'h00000000, "mult_min");
    run_mul(OP_MULTU, 32'h0000002D, 32'h00000068, 32'h00000000, 32'h00001248, "multu_small");
    run_mul(OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg");
    run_mul(OP_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, "multu_hib");

    // Moves and reads while idle, plus an undefined encoding.
    op = OP_MTHI; rs_val = 32'hCAFEBABE; tick;
    op = OP_MTLO; rs_val = 32'h0BADF00D; tick;
    chk("mt_hilo", {hi, lo}, 64'hCAFEBABE_0BADF00D);
    op = OP_MFHI; #1;
    chk("mfhi", {32'd0, rd_data}, 64'h00000000_CAFEBABE);
    op = OP_MFLO; #1;
    chk("mflo", {32'd0, rd_data}, 64'h00000000_0BADF00D);
    op = 3'd7; rs_val = 32'h11111111; #1;
    chk("undef_rd", {32'd0, rd_data}, 64'd0);
    tick;
    chk("undef_noeffect", {hi, lo, 31'd0, busy}, {64'hCAFEBABE_0BADF00D, 32'd0});

    // Ops presented during WAIT stall; MFLO gets the forwarded product on done.
    op = OP_MULT; rs_val = 32'h0000002D; rt_val = 32'h00000068; tick;
    op = OP_MTHI; rs_val = 32'hDEADBEEF; #1;
    chk("wait_mthi_stall", {63'd0, stall}, 64'd1);
    op = 3'd7; #1;
    chk("wait_undef_nostall", {63'd0, stall}, 64'd0);
    tick;
    op = OP_MFLO; #1;
    chk("wait_mflo_stall1", {63'd0, stall}, 64'd1);
    tick;
    chk("wait_mflo_stall2", {63'd0, stall}, 64'd1);
    tick;
    chk("done_mflo", {30'd0, stall, done, rd_data}, {32'd1, 32'h00001248});
    op = OP_MFHI; #1;
    chk("done_mfhi", {32'd0, rd_data}, 64'd0);
    tick;
    op = OP_NOP;
    chk("fwd_hilo", {hi, lo}, 64'h00000000_00001248);

    // A multiply presented on the done cycle is accepted straight away.
    op = OP_MULT; rs_val = 32'd3; rt_val = 32'd4; tick;
    op = OP_NOP; tick; tick; tick;
    op = OP_MULTU; rs_val = 32'd5; rt_val = 32'd6; #1;
    chk("b2b_accept", {62'd0, stall, done}, 64'd1);
    tick;
    op = OP_NOP;
    chk("b2b_first", {hi, lo, 31'd0, busy}, {64'd12, 32'd1});
    chk("b2b_mula", {32'd0, mul_a}, 64'd5);
    tick; tick; tick;
    chk("b2b_done", {63'd0, done}, 64'd1);
    tick;
    chk("b2b_second", {hi, lo}, 64'd30);

    // Reset in the middle of WAIT aborts the multiply.
    op = OP_MULT; rs_val = 32'd2; rt_val = 32'd3; tick;
    op = OP_NOP; tick;
    #2 reset = 1'b1;
    op = OP_MFHI; #1;
    chk("arst_flags", {61'd0, busy, stall, done}, 64'd0);
    chk("arst_hilo", {hi, lo}, 64'd0);
    chk("arst_mul", {mul_a, mul_b}, 64'd0);
    op = OP_NOP;
    @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    for (int k = 0; k < LAT + 3; k++) begin
      tick;
      if (done) n_done++;
    end
    chk("arst_no_done", 64'(n_done), 64'd0);
    chk("arst_lo", {32'd0, lo}, 64'd0);
    op = OP_MTHI; rs_val = 32'h12345678; tick;
    op = OP_NOP;
    chk("arst_mthi", {hi, lo}, 64'h12345678_00000000);
    chk("arst_idle", {62'd0, busy, done}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
